a0_uart_tx: RTL
===============

# a0_uart_tx

Serial monitor port for the single-cycle core's result register. It watches the register file's `a0` output, queues every new value in a small FIFO, and transmits each queued word to a host as 8N1 UART frames, least-significant byte first. It sits at top level beside the register file and is the read side of the `a0` observation path, so the bench and the board can see program results without the simulator console.

## Interface
- `D_WIDTH`, 32, width of the watched word; must be a multiple of 8 (`D_WIDTH/8` bytes per word).
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; must be at least 2.
- `FIFO_DEPTH`, 4, number of queued words; must be a power of two and at least 2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a0`  in  D_WIDTH  current value of register x10 from the register file.
- `en`  in  1  capture enable; when low, no new captures and `a0_prev` is frozen.
- `tx`  out  1  UART line; idles high.
- `busy`  out  1  high while a frame is on the line (any state other than IDLE).
- `overflow`  out  1  sticky; set when a capture is dropped because the FIFO is full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of words currently queued.

## Operation
- Reset value of every output and internal register:
  - `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0.
  - `a0_prev`=0, FSM in IDLE, all counters 0.
- Capture (change detector):
  - Each edge with `en`=1: `a0_prev` <= `a0`.
  - If `a0` != `a0_prev` on that edge, push `a0`.
  - A constant `a0` is therefore captured exactly once. A nonzero value present when reset is released is captured on the first enabled edge.
- FIFO push/pop rules:
  - A push is accepted when not full, or when full and a pop happens on the same edge.
  - Otherwise the push is dropped and `overflow` <= 1. `overflow` clears only on reset.
  - Simultaneous push and pop leaves `fifo_count` unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop the head into the shift register, set byte index 0, go to START. A word pushed on edge N cannot be popped before edge N+1.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: send the 8 bits of the current byte LSB first, each held `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles.
    - If the byte index is below `D_WIDTH/8`-1, increment it, shift the word right by 8, and go to START.
    - Otherwise go to IDLE.
- `tx` is driven from a register, so it is glitch-free. `busy` = (state != IDLE).
- Assertion of `rst_n` mid-frame aborts immediately: `tx`=1 and the FIFO is emptied; the partial frame is lost.

## Timing
- Capture latency: `a0` changes before edge N, is pushed at edge N, and `fifo_count` increments after edge N.
- Start latency from an empty, idle state: pop at edge N+1, `tx` falls after edge N+1, `busy` rises after edge N+1.
- Frame length: 10×`CLKS_PER_BIT` cycles. Word length: (`D_WIDTH/8`)×10×`CLKS_PER_BIT` cycles (640 at the defaults), with no idle gap between the bytes of one word.
- Back-to-back words: after the final STOP completes, one IDLE cycle, then the next START. The gap between words is exactly 1 cycle when the FIFO is non-empty.
- Bit sample point for the bench: middle of each bit, at `CLKS_PER_BIT`/2 cycles after the bit starts.

## Test plan
- Reset behaviour: hold `rst_n`=0 with `a0`=0x12345678 and `en`=1 -> `tx`=1, `busy`=0, `fifo_count`=0. After release, exactly one capture occurs and its frames decode to bytes 0x78, 0x56, 0x34, 0x12, in that order, with no gap between them.
- Single word timing: from idle, set `a0`=0x000000A5 with `CLKS_PER_BIT`=16 ->
  - `tx` falls 2 cycles after the change edge.
  - First byte decodes as 0xA5, followed by three 0x00 bytes.
  - `busy` stays high for exactly 640 cycles.
- No duplicate capture: hold `a0` constant for 2000 cycles after one change -> exactly one word is transmitted.
- Capture gating: toggle `a0` while `en`=0 -> no push. Then raise `en` -> one push, of the then-current value, only if it differs from `a0_prev`.
- Overflow with default depth 4:
  - Apply 6 distinct values on consecutive cycles during a transmission -> `fifo_count` saturates at 4, `overflow`=1 and stays 1.
  - The transmitted sequence is the in-flight word followed by the first 4 queued values; the 5th and 6th are lost.
- Full plus simultaneous pop: with the FIFO full, push on the exact IDLE pop edge -> the push is accepted, `fifo_count` stays 4, `overflow` stays 0.
- Reset mid-frame: assert `rst_n` during DATA of byte 2 -> `tx`=1 immediately, `fifo_count`=0, and no further frames are sent.

Source files
------------

// File: rtl/a0_uart_tx.sv
// Watches the a0 result register, queues each new value, and sends every queued word
// over an 8N1 UART line, least-significant byte first.
module a0_uart_tx #(
   parameter int unsigned D_WIDTH      = 32,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [D_WIDTH-1:0]            a0,
   input  logic                          en,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned NB = D_WIDTH / 8;
   localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state, state_nx;
   logic [TW-1:0]        tmr, tmr_nx;
   logic [2:0]           bit_idx, bit_nx;
   logic [BW-1:0]        byte_idx, byte_nx;
   logic [D_WIDTH-1:0]   shreg, sh_nx;
   logic                 tx_nx;

   logic [D_WIDTH-1:0]   a0_prev;
   logic [D_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;

   logic                 push, push_ok, pop, full, empty, bit_end, last_byte;
   logic [7:0]           cur_byte;

   assign push      = en && (a0 != a0_prev);
   assign full      = (fifo_count == CW'(FIFO_DEPTH));
   assign empty     = (fifo_count == '0);
   assign pop       = (state == IDLE) && !empty;
   // When full, a push still fits if the head leaves on the same edge.
   assign push_ok   = push && (!full || pop);
   assign bit_end   = (tmr == TW'(CLKS_PER_BIT - 1));
   assign last_byte = (byte_idx == BW'(NB - 1));
   assign cur_byte  = shreg[7:0];

   // Change detector and FIFO bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a0_prev    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (en) a0_prev <= a0;
         if (push && !push_ok) overflow <= 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= a0;
   end

   // Transmit state register; tx and busy are registered from their next values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tmr      <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         tmr      <= tmr_nx;
         bit_idx  <= bit_nx;
         byte_idx <= byte_nx;
         shreg    <= sh_nx;
         tx       <= tx_nx;
         busy     <= (state_nx != IDLE);
      end
   end

   always_comb begin
      state_nx = state;
      tmr_nx   = tmr;
      bit_nx   = bit_idx;
      byte_nx  = byte_idx;
      sh_nx    = shreg;
      tx_nx    = 1'b1;
      case (state)
         IDLE: begin
            if (!empty) begin
               state_nx = START;
               sh_nx    = mem[rd_ptr];
               byte_nx  = '0;
               tmr_nx   = '0;
               tx_nx    = 1'b0;
            end
         end
         START: begin
            tx_nx = 1'b0;
            if (bit_end) begin
               state_nx = DATA;
               tmr_nx   = '0;
               bit_nx   = '0;
               tx_nx    = cur_byte[0];
            end else begin
               tmr_nx = tmr + TW'(1);
            end
         end
         DATA: begin
            tx_nx = cur_byte[bit_idx];
            if (bit_end) begin
               tmr_nx = '0;
               if (bit_idx == 3'd7) begin
                  state_nx = STOP;
                  tx_nx    = 1'b1;
               end else begin
                  bit_nx = bit_idx + 3'd1;
                  tx_nx  = cur_byte[bit_idx + 3'd1];
               end
            end else begin
               tmr_nx = tmr + TW'(1);
            end
         end
         STOP: begin
            tx_nx = 1'b1;
            if (bit_end) begin
               tmr_nx = '0;
               if (!last_byte) begin
                  state_nx = START;
                  byte_nx  = byte_idx + BW'(1);
                  sh_nx    = shreg >> 8;
                  tx_nx    = 1'b0;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               tmr_nx = tmr + TW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
